// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM for the multi-cycle RV32I core. Sequences the shared ALU,
//   memories and register file over 3-5 cycles per instruction. Outputs are
//   Moore decodes of the current state and the latched decode fields. The one
//   exception is PCWrite in BEQ, which follows Zero in the same cycle.
//
//   op/funct3/funct7b5 come straight from instruction memory. That output
//   changes once PC advances, so the fields are captured at the FETCH edge.
//   All later states decode only from the captured copies.
//
// Ports
//   clk, reset         rising-edge clock; synchronous active-high reset
//   op, funct3,        fetched instruction fields, valid in FETCH
//   funct7b5
//   Zero               ALU zero flag (BEQ branch decision)
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
//   ALUSrcB, ALUSrcA, ImmSrc, RegWrite   datapath selects and enables
//   state              current state encoding (debug)
//   illegal            sticky illegal-opcode flag
//
// Configuration
//   MC_CTRL_ILLEGAL_TRAP_EN
//     Defined:   an unknown opcode parks the FSM in TRAP with illegal=1
//                until reset.
//     Undefined: an unknown opcode is a 2-cycle NOP and illegal is tied to 0.
// ----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        TRAP     = 4'd15
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q, state_d;
    logic [6:0] op_q;
    logic [2:0] funct3_q;
    logic       f7b5_q;
    logic [2:0] alu_dec;

    // State register and decode-field latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            op_q     <= '0;
            funct3_q <= '0;
            f7b5_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                op_q     <= op;
                funct3_q <= funct3;
                f7b5_q   <= funct7b5;
            end
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (state_q == DECODE && state_d == TRAP)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q & ~reset;
`else
    assign illegal = 1'b0;
`endif

    assign state = reset ? 4'd0 : state_q;

    // ALU operation from funct3. The sub/add split on bit 30 applies only to
    // R-type, because an I-type addi uses bit 30 as part of its immediate.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3_q)
            3'b000:  alu_dec = (state_q == EXECUTER && f7b5_q) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ALUSrcB    = 2'b00;
        ALUSrcA    = 2'b00;
        ImmSrc     = 2'b00;
        RegWrite   = 1'b0;

        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                // Branch/jump target (OldPC + imm) lands in ALUOut here.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op_q == OP_JAL) ? 2'b11 : 2'b10;
                case (op_q)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BEQ:            state_d = BEQ;
                    OP_JAL:            state_d = JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:           state_d = TRAP;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op_q == OP_STORE) ? 2'b01 : 2'b00;
                state_d = (op_q == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
                state_d    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
            end
            JAL: begin
                // Computes OldPC+4 for the link; PC takes the target from ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: state_d = FETCH;
        endcase

        // Enables must be quiet in the reset cycle so an aborted instruction
        // leaves no partial write behind.
        if (reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b00;
            ALUControl = ALU_ADD;
            ALUSrcB    = 2'b00;
            ALUSrcA    = 2'b00;
            ImmSrc     = 2'b00;
            RegWrite   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcB, ALUSrcA, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
    //  ALUSrcB, ALUSrcA, ImmSrc, RegWrite, illegal}
    function automatic logic [20:0] mk(logic [3:0] st, logic pcw, logic adr, logic mw,
                                       logic irw, logic [1:0] rs, logic [2:0] alu,
                                       logic [1:0] sb, logic [1:0] sa, logic [1:0] imm,
                                       logic rw, logic ill);
        return {st, pcw, adr, mw, irw, rs, alu, sb, sa, imm, rw, ill};
    endfunction

    function automatic logic [20:0] observed();
        return {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                ALUSrcB, ALUSrcA, ImmSrc, RegWrite, illegal};
    endfunction

    task automatic push(input string tag, input logic [20:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    // Pops and checks one expectation per cycle. Fetch fields are scrambled
    // after the first cycle to show later states ignore the live inputs.
    task automatic drain();
        bit   first = 1'b1;
        exp_t e;
        logic [20:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            obs = observed();
            vectors++;
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
            end
            @(posedge clk);
            #1;
            if (first) begin
                op       = 7'b0100011;
                funct3   = 3'b101;
                funct7b5 = ~funct7b5;
                first    = 1'b0;
            end
        end
    endtask

    task automatic fetch_fields(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [20:0] RST, F, DEC_B, DEC_J, ADR_L, ADR_S, MRD, MWB, MWR, AWB, JL;

        RST   = mk(4'd0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
        F     = mk(4'd0, 1, 0, 0, 1, 2'b10, 3'b000, 2'b10, 2'b00, 2'b00, 0, 0);
        DEC_B = mk(4'd1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b10, 0, 0);
        DEC_J = mk(4'd1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b11, 0, 0);
        ADR_L = mk(4'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b00, 0, 0);
        ADR_S = mk(4'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b01, 0, 0);
        MRD   = mk(4'd3, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
        MWB   = mk(4'd4, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
        MWR   = mk(4'd5, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
        AWB   = mk(4'd8, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
        JL    = mk(4'd10, 1, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0);

        // Reset held 3 cycles with live-looking fetch fields on the inputs.
        reset = 1'b1;
        fetch_fields(7'b0000011, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) push("reset", RST);
        drain();
        reset = 1'b0;

        // lw: 0,1,2,3,4
        fetch_fields(7'b0000011, 3'b010, 1'b0, 1'b1);
        push("lw_fetch", F); push("lw_dec", DEC_B); push("lw_adr", ADR_L);
        push("lw_rd", MRD); push("lw_wb", MWB);
        drain();

        // sw: 0,1,2,5
        fetch_fields(7'b0100011, 3'b010, 1'b0, 1'b1);
        push("sw_fetch", F); push("sw_dec", DEC_B); push("sw_adr", ADR_S); push("sw_wr", MWR);
        drain();

        // R-type sub / add
        fetch_fields(7'b0110011, 3'b000, 1'b1, 1'b1);
        push("r_fetch", F); push("r_dec", DEC_B);
        push("r_sub", mk(4'd6, 0, 0, 0, 0, 2'b00, 3'b001, 2'b00, 2'b10, 2'b00, 0, 0));
        push("r_wb", AWB);
        drain();
        fetch_fields(7'b0110011, 3'b000, 1'b0, 1'b1);
        push("r_fetch", F); push("r_dec", DEC_B);
        push("r_add", mk(4'd6, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0));
        push("r_wb", AWB);
        drain();
        fetch_fields(7'b0110011, 3'b110, 1'b0, 1'b1);
        push("r_fetch", F); push("r_dec", DEC_B);
        push("r_or", mk(4'd6, 0, 0, 0, 0, 2'b00, 3'b011, 2'b00, 2'b10, 2'b00, 0, 0));
        push("r_wb", AWB);
        drain();

        // I-type: addi with bit30=1 must still add; and/slt/unlisted funct3
        fetch_fields(7'b0010011, 3'b000, 1'b1, 1'b1);
        push("i_fetch", F); push("i_dec", DEC_B);
        push("i_addi", mk(4'd7, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b00, 0, 0));
        push("i_wb", AWB);
        drain();
        fetch_fields(7'b0010011, 3'b111, 1'b0, 1'b1);
        push("i_fetch", F); push("i_dec", DEC_B);
        push("i_andi", mk(4'd7, 0, 0, 0, 0, 2'b00, 3'b010, 2'b01, 2'b10, 2'b00, 0, 0));
        push("i_wb", AWB);
        drain();
        fetch_fields(7'b0010011, 3'b010, 1'b0, 1'b1);
        push("i_fetch", F); push("i_dec", DEC_B);
        push("i_slti", mk(4'd7, 0, 0, 0, 0, 2'b00, 3'b101, 2'b01, 2'b10, 2'b00, 0, 0));
        push("i_wb", AWB);
        drain();
        fetch_fields(7'b0010011, 3'b001, 1'b0, 1'b1);
        push("i_fetch", F); push("i_dec", DEC_B);
        push("i_f3_001", mk(4'd7, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b00, 0, 0));
        push("i_wb", AWB);
        drain();

        // beq taken / not taken
        fetch_fields(7'b1100011, 3'b000, 1'b0, 1'b1);
        push("beq_fetch", F); push("beq_dec", DEC_B);
        push("beq_taken", mk(4'd9, 1, 0, 0, 0, 2'b00, 3'b001, 2'b00, 2'b10, 2'b00, 0, 0));
        drain();
        fetch_fields(7'b1100011, 3'b000, 1'b0, 1'b0);
        push("beq_fetch", F); push("beq_dec", DEC_B);
        push("beq_not", mk(4'd9, 0, 0, 0, 0, 2'b00, 3'b001, 2'b00, 2'b10, 2'b00, 0, 0));
        drain();

        // jal: 0,1,10,8
        fetch_fields(7'b1101111, 3'b000, 1'b0, 1'b0);
        push("jal_fetch", F); push("jal_dec", DEC_J); push("jal_jal", JL); push("jal_wb", AWB);
        drain();

        // Reset in the middle of a load aborts it with no enables asserted.
        fetch_fields(7'b0000011, 3'b010, 1'b0, 1'b1);
        push("mid_fetch", F); push("mid_dec", DEC_B); push("mid_adr", ADR_L);
        drain();
        reset = 1'b1;
        push("mid_reset", RST);
        drain();
        reset = 1'b0;

        // Unknown opcode
        fetch_fields(7'b1111111, 3'b000, 1'b0, 1'b1);
        push("ill_fetch", F); push("ill_dec", DEC_B);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++)
            push("ill_trap", mk(4'd15, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 1));
        drain();
        reset = 1'b1;
        push("ill_reset", RST);
        drain();
        reset = 1'b0;
`else
        drain();
`endif

        // Back in FETCH after the last instruction.
        fetch_fields(7'b0110011, 3'b000, 1'b0, 1'b0);
        push("final_fetch", F);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
